// File: rtl/mem_sel_unit_if.sv
// mem_sel_unit_if: request, response and SRAM port bundle for mem_sel_unit
interface mem_sel_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [1:0] req_size;
  logic req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic rsp_adel;
  logic rsp_ades;
  logic sram_en;
  logic [DATA_W/8-1:0] sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic sram_gnt;
  logic [DATA_W-1:0] sram_rdata;
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, sram_gnt, sram_rdata,
    input req_ready, rsp_valid, rsp_rdata, rsp_adel, rsp_ades, sram_en, sram_we, sram_addr, sram_wdata
  );
  modport slave (
    input req_valid, req_we, req_size, req_signed, req_addr, req_wdata, sram_gnt, sram_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_adel, rsp_ades, sram_en, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/mem_sel_unit.sv
// mem_sel_unit: sequential load/store byte-select stage in front of the data SRAM; MEMSEL_BADVADDR_EN adds the bad_vaddr register
module mem_sel_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst,
  mem_sel_unit_if.slave bus
`ifdef MEMSEL_BADVADDR_EN
  ,
  output logic [ADDR_W-1:0] bad_vaddr
`endif
);
  localparam int BYTES = DATA_W / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int CNT_W = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  localparam logic [1:0] IDLE = 2'd0, ACC = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic we_q, sgn_q, err_q;
  logic [3:0] nb_q, nb;
  logic [LANE_W-1:0] lane_q, lane;
  logic [ADDR_W-1:LANE_W] base_q;
  logic [BYTES-1:0] be_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, sh, msk, ext;
  logic mis, accept;
  always_comb begin
    nb = 4'd1 << bus.req_size;
    lane = bus.req_addr[LANE_W-1:0];
    mis = nb > 4'(BYTES) || |(bus.req_addr[2:0] & 3'(nb - 4'd1));
    accept = bus.req_valid && bus.req_ready;
    sh = bus.sram_rdata >> {lane_q, 3'b0};
    // a shift by the full width yields 0, so the mask wraps to all ones for full-width loads
    msk = (DATA_W'(1) << {nb_q, 3'b0}) - DATA_W'(1);
    ext = (sh & msk) | (sgn_q && |(sh & (msk ^ (msk >> 1))) ? ~msk : '0);
  end
  assign bus.req_ready = state == IDLE && !rst;
  assign bus.sram_en = state == ACC;
  assign bus.sram_we = bus.sram_en && we_q ? be_q : '0;
  assign bus.sram_addr = bus.sram_en ? {base_q, LANE_W'(0)} : '0;
  assign bus.sram_wdata = bus.sram_en ? wdata_q : '0;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_rdata = bus.rsp_valid && !we_q && !err_q ? rdata_q : '0;
  assign bus.rsp_adel = bus.rsp_valid && err_q && !we_q;
  assign bus.rsp_ades = bus.rsp_valid && err_q && we_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          we_q <= bus.req_we;
          sgn_q <= bus.req_signed;
          err_q <= mis;
          nb_q <= nb;
          lane_q <= lane;
          base_q <= bus.req_addr[ADDR_W-1:LANE_W];
          be_q <= BYTES'(((16'd1 << nb) - 16'd1) << lane);
          wdata_q <= bus.req_wdata << {lane, 3'b0};
          state <= mis ? RESP : ACC;
        end
        ACC: if (bus.sram_gnt) begin
          state <= we_q ? RESP : WAIT;
          cnt <= CNT_W'(RD_LAT - 1);
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            rdata_q <= ext;
            state <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef MEMSEL_BADVADDR_EN
  always_ff @(posedge clk) begin
    if (rst) bad_vaddr <= '0;
    else if (accept && mis) bad_vaddr <= bus.req_addr;
  end
`endif
endmodule

// File: tb/tb_mem_sel_unit.sv
// tb_mem_sel_unit: table vectors, reset sequences and random transactions on three configurations
module tb_mem_sel_unit;
  typedef struct packed {
    int lat;
    logic adel;
    logic ades;
    logic [63:0] rdata;
    logic [31:0] saddr;
    logic [7:0] be;
    logic [63:0] wdata;
    int en_cnt;
  } exp_t;
  typedef struct packed {
    int s;
    logic we;
    logic [1:0] sz;
    logic sg;
    logic [31:0] a;
    logic [63:0] wd;
    logic [63:0] rd;
    int gd;
    exp_t e;
  } vec_t;
  typedef struct packed {
    int lat;
    int nrsp;
    int en_first;
    int en_cnt;
    logic rb;
    logic ra;
    logic adel;
    logic ades;
    logic stable;
    logic [63:0] rdata;
    logic [63:0] wdata;
    logic [7:0] be;
    logic [31:0] addr;
    logic [31:0] bad;
  } obs_t;

  logic clk = 0;
  always #5 clk = ~clk;
  logic rst;
  int sel;
  logic req_valid, req_we, req_signed, sram_gnt;
  logic [1:0] req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, sram_rdata;
  logic o_ready, o_rv, o_adel, o_ades, o_en;
  logic [7:0] o_be;
  logic [31:0] o_addr, o_bad;
  logic [63:0] o_rdata, o_wdata;
  logic [31:0] bad0, bad1, bad2;
  int checks = 0;
  int failures = 0;

  mem_sel_unit_if #(.DATA_W(32), .ADDR_W(32)) if0 ();
  mem_sel_unit_if #(.DATA_W(32), .ADDR_W(32)) if1 ();
  mem_sel_unit_if #(.DATA_W(64), .ADDR_W(32)) if2 ();

  assign if0.req_valid = req_valid && sel == 0;
  assign if0.req_we = req_we;
  assign if0.req_size = req_size;
  assign if0.req_signed = req_signed;
  assign if0.req_addr = req_addr;
  assign if0.req_wdata = req_wdata[31:0];
  assign if0.sram_gnt = sram_gnt;
  assign if0.sram_rdata = sram_rdata[31:0];
  assign if1.req_valid = req_valid && sel == 1;
  assign if1.req_we = req_we;
  assign if1.req_size = req_size;
  assign if1.req_signed = req_signed;
  assign if1.req_addr = req_addr;
  assign if1.req_wdata = req_wdata[31:0];
  assign if1.sram_gnt = sram_gnt;
  assign if1.sram_rdata = sram_rdata[31:0];
  assign if2.req_valid = req_valid && sel == 2;
  assign if2.req_we = req_we;
  assign if2.req_size = req_size;
  assign if2.req_signed = req_signed;
  assign if2.req_addr = req_addr;
  assign if2.req_wdata = req_wdata;
  assign if2.sram_gnt = sram_gnt;
  assign if2.sram_rdata = sram_rdata;

  mem_sel_unit #(.DATA_W(32), .ADDR_W(32), .RD_LAT(1)) u0 (.clk(clk), .rst(rst), .bus(if0)
`ifdef MEMSEL_BADVADDR_EN
    , .bad_vaddr(bad0)
`endif
  );
  mem_sel_unit #(.DATA_W(32), .ADDR_W(32), .RD_LAT(3)) u1 (.clk(clk), .rst(rst), .bus(if1)
`ifdef MEMSEL_BADVADDR_EN
    , .bad_vaddr(bad1)
`endif
  );
  mem_sel_unit #(.DATA_W(64), .ADDR_W(32), .RD_LAT(2)) u2 (.clk(clk), .rst(rst), .bus(if2)
`ifdef MEMSEL_BADVADDR_EN
    , .bad_vaddr(bad2)
`endif
  );

  always_comb begin
    case (sel)
      0: {o_ready, o_rv, o_adel, o_ades, o_en, o_be, o_addr, o_rdata, o_wdata} =
           {if0.req_ready, if0.rsp_valid, if0.rsp_adel, if0.rsp_ades, if0.sram_en, 4'b0, if0.sram_we,
            if0.sram_addr, 32'b0, if0.rsp_rdata, 32'b0, if0.sram_wdata};
      1: {o_ready, o_rv, o_adel, o_ades, o_en, o_be, o_addr, o_rdata, o_wdata} =
           {if1.req_ready, if1.rsp_valid, if1.rsp_adel, if1.rsp_ades, if1.sram_en, 4'b0, if1.sram_we,
            if1.sram_addr, 32'b0, if1.rsp_rdata, 32'b0, if1.sram_wdata};
      default: {o_ready, o_rv, o_adel, o_ades, o_en, o_be, o_addr, o_rdata, o_wdata} =
           {if2.req_ready, if2.rsp_valid, if2.rsp_adel, if2.rsp_ades, if2.sram_en, if2.sram_we,
            if2.sram_addr, if2.rsp_rdata, if2.sram_wdata};
    endcase
    o_bad = sel == 0 ? bad0 : sel == 1 ? bad1 : bad2;
  end

  function automatic int rl(input int s);
    return s == 1 ? 3 : s == 2 ? 2 : 1;
  endfunction

  function automatic int dw(input int s);
    return s == 2 ? 64 : 32;
  endfunction

  // reference: byte-granular view of the access, no shifts or masks
  function automatic exp_t model(input int s, input logic we, input logic [1:0] sz, input logic sg,
                                 input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rd, input int gd);
    exp_t e;
    int nb, bytes, lane;
    logic [63:0] v;
    e = '0;
    nb = 1 << sz;
    bytes = dw(s) / 8;
    lane = int'(a % 32'(bytes));
    if (nb > bytes || (a % 32'(nb)) != 0) begin
      e.lat = 1;
      e.adel = !we;
      e.ades = we;
      return e;
    end
    e.saddr = a - 32'(lane);
    e.en_cnt = gd + 1;
    e.lat = we ? 2 + gd : 2 + gd + rl(s);
    if (we) begin
      for (int i = lane; i < lane + nb; i++) e.be[i] = 1'b1;
      for (int i = lane; i < bytes; i++) e.wdata[8*i +: 8] = wd[8*(i-lane) +: 8];
    end else begin
      v = '0;
      for (int k = 0; k < nb; k++) v[8*k +: 8] = rd[8*(lane+k) +: 8];
      if (sg && v[8*nb-1]) for (int k = nb; k < bytes; k++) v[8*k +: 8] = 8'hFF;
      e.rdata = v;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic run(input int s, input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                     input logic [63:0] wd, input logic [63:0] rd, input int gd, input logic junk, output obs_t o);
    int g;
    g = -1;
    o = '0;
    o.stable = 1'b1;
    @(negedge clk);
    sel = s;
    req_valid = 1;
    req_we = we;
    req_size = sz;
    req_signed = sg;
    req_addr = a;
    req_wdata = wd;
    sram_gnt = 0;
    #1 o.rb = o_ready;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      req_valid = junk && o.lat == 0;
      if (junk) begin
        req_we = 1'($urandom);
        req_size = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr = $urandom;
        req_wdata = {$urandom, $urandom};
      end
      if (o_en) begin
        o.en_cnt++;
        if (o.en_cnt == 1) begin
          o.en_first = c;
          o.be = o_be;
          o.addr = o_addr;
          o.wdata = o_wdata;
        end else if ({o_be, o_addr, o_wdata} !== {o.be, o.addr, o.wdata}) o.stable = 1'b0;
        if (o.en_cnt == gd + 1) g = c;
      end
      sram_gnt = o_en ? o.en_cnt == gd + 1 : 1'($urandom);
      sram_rdata = (g >= 0 && c == g + rl(s)) ? rd : {$urandom, $urandom};
      if (o_rv) begin
        o.nrsp++;
        if (o.lat == 0) begin
          o.lat = c;
          o.adel = o_adel;
          o.ades = o_ades;
          o.rdata = o_rdata;
          o.bad = o_bad;
        end
        req_valid = 0;
      end
      if (o.lat != 0 && c == o.lat + 1) begin
        o.ra = o_ready;
        break;
      end
    end
  endtask

  task automatic cmp(input string t, input logic we, input logic [31:0] a, input obs_t o, input exp_t e);
    chk({t, ".lat"}, 64'(o.lat), 64'(e.lat));
    chk({t, ".nrsp"}, 64'(o.nrsp), 64'd1);
    chk({t, ".ready_before"}, 64'(o.rb), 64'd1);
    chk({t, ".ready_after"}, 64'(o.ra), 64'd1);
    chk({t, ".adel"}, 64'(o.adel), 64'(e.adel));
    chk({t, ".ades"}, 64'(o.ades), 64'(e.ades));
    chk({t, ".rdata"}, o.rdata, e.rdata);
    chk({t, ".en_cycles"}, 64'(o.en_cnt), 64'(e.en_cnt));
    if (e.en_cnt > 0) begin
      chk({t, ".en_first"}, 64'(o.en_first), 64'd1);
      chk({t, ".saddr"}, 64'(o.addr), 64'(e.saddr));
      chk({t, ".be"}, 64'(o.be), 64'(e.be));
      chk({t, ".stable"}, 64'(o.stable), 64'd1);
      if (we) chk({t, ".wdata"}, o.wdata, e.wdata);
    end
`ifdef MEMSEL_BADVADDR_EN
    if (e.adel || e.ades) chk({t, ".bad_vaddr"}, 64'(o.bad), 64'(a));
`endif
  endtask

  task automatic rst_seq(input int s, input logic in_wait);
    int n;
    n = 0;
    @(negedge clk);
    sel = s;
    req_valid = 1;
    req_we = 0;
    req_size = 2'd2;
    req_signed = 0;
    req_addr = 32'h100;
    sram_gnt = 0;
    @(negedge clk);
    req_valid = 0;
    chk("rs.en_acc", 64'(o_en), 64'd1);
    sram_gnt = in_wait;
    if (in_wait) begin
      @(negedge clk);
      sram_gnt = 0;
      chk("rs.en_wait", 64'(o_en), 64'd0);
    end
    rst = 1;
    @(negedge clk);
    chk("rs.en_rst", 64'(o_en), 64'd0);
    chk("rs.ready_rst", 64'(o_ready), 64'd0);
    n += int'(o_rv);
    rst = 0;
    @(negedge clk);
    chk("rs.ready_after", 64'(o_ready), 64'd1);
    repeat (8) begin
      n += int'(o_rv);
      @(negedge clk);
    end
    chk("rs.no_rsp", 64'(n), 64'd0);
  endtask

  vec_t tv[$];

  task automatic add(input int s, input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                     input logic [63:0] wd, input logic [63:0] rd, input int gd, input int lat, input logic adel,
                     input logic ades, input logic [63:0] rdata, input logic [31:0] saddr, input logic [7:0] be,
                     input logic [63:0] wdata);
    vec_t v;
    v.s = s; v.we = we; v.sz = sz; v.sg = sg; v.a = a; v.wd = wd; v.rd = rd; v.gd = gd;
    v.e.lat = lat; v.e.adel = adel; v.e.ades = ades; v.e.rdata = rdata; v.e.saddr = saddr;
    v.e.be = be; v.e.wdata = wdata; v.e.en_cnt = (adel || ades) ? 0 : gd + 1;
    tv.push_back(v);
  endtask

  initial begin
    obs_t o;
    exp_t e;
    int s, gd;
    logic we, sg;
    logic [1:0] sz;
    logic [31:0] a;
    logic [63:0] wd, rd;
    rst = 1; sel = 0; req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
    req_addr = 0; req_wdata = 0; sram_gnt = 0; sram_rdata = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      chk("reset.ready", 64'(o_ready), 64'd0);
      chk("reset.rsp_valid", 64'(o_rv), 64'd0);
      chk("reset.sram_en", 64'(o_en), 64'd0);
      chk("reset.sram_addr", 64'(o_addr), 64'd0);
      chk("reset.sram_we", 64'(o_be), 64'd0);
`ifdef MEMSEL_BADVADDR_EN
      chk("reset.bad_vaddr", 64'(o_bad), 64'd0);
`endif
    end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset.ready_release", 64'(o_ready), 64'd1);
    add(0, 0, 0, 1, 32'h1003, 0, 64'h80FF_1234, 0, 3, 0, 0, 64'hFFFF_FF80, 32'h1000, 0, 0);
    add(0, 1, 1, 0, 32'h2002, 64'hBEEF, 0, 0, 2, 0, 0, 0, 32'h2000, 8'h0C, 64'hBEEF_0000);
    add(0, 0, 2, 0, 32'h3001, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 3, 0, 32'h3000, 64'h1234, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h4006, 0, 64'h8001_0000, 2, 7, 0, 0, 64'h8001, 32'h4004, 0, 0);
    add(2, 1, 0, 0, 32'h5005, 64'hAA, 0, 0, 2, 0, 0, 0, 32'h5000, 8'h20, 64'h0000_AA00_0000_0000);
    add(2, 0, 3, 1, 32'h5008, 0, 64'h0123_4567_89AB_CDEF, 0, 4, 0, 0, 64'h0123_4567_89AB_CDEF, 32'h5008, 0, 0);
    add(0, 0, 1, 1, 32'h0010, 0, 64'h1234_F00D, 1, 4, 0, 0, 64'hFFFF_F00D, 32'h0010, 0, 0);
    add(2, 0, 2, 0, 32'h6004, 0, 64'h89AB_CDEF_0000_0000, 0, 4, 0, 0, 64'h89AB_CDEF, 32'h6000, 0, 0);
    add(2, 0, 2, 1, 32'h6004, 0, 64'h89AB_CDEF_0000_0000, 0, 4, 0, 0, 64'hFFFF_FFFF_89AB_CDEF, 32'h6000, 0, 0);
    add(2, 0, 2, 0, 32'h6002, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 2, 0, 32'h7000, 64'hDEAD_BEEF, 0, 3, 5, 0, 0, 0, 32'h7000, 8'h0F, 64'hDEAD_BEEF);
    add(2, 1, 3, 0, 32'h5010, 64'h1122_3344_5566_7788, 0, 1, 3, 0, 0, 0, 32'h5010, 8'hFF, 64'h1122_3344_5566_7788);
    foreach (tv[i]) begin
      run(tv[i].s, tv[i].we, tv[i].sz, tv[i].sg, tv[i].a, tv[i].wd, tv[i].rd, tv[i].gd, 1'b0, o);
      cmp($sformatf("vec%0d", i), tv[i].we, tv[i].a, o, tv[i].e);
    end
    rst_seq(1, 1'b1);
    rst_seq(0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      s = $urandom_range(0, 2);
      we = 1'($urandom);
      sz = 2'($urandom);
      sg = 1'($urandom);
      a = ($urandom & 32'hFFFF_FFF8) | 32'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      wd = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      gd = $urandom_range(0, 3);
      e = model(s, we, sz, sg, a, wd, rd, gd);
      run(s, we, sz, sg, a, wd, rd, gd, 1'($urandom), o);
      cmp($sformatf("rnd%0d", i), we, a, o, e);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_sel_unit.md
# mem_sel_unit

Parametrised, sequential successor to the combinational byte-select stage. It sits between the MEM stage and the data SRAM port. It accepts one load/store request per transaction, checks alignment, drives byte enables and lane-shifted write data, and waits out SRAM grant and read latency. It returns one response carrying extended load data or an address-error flag.

## Interface
- DATA_W, 32: data path width; 32 or 64. BYTES = DATA_W/8; LANE_W = log2(BYTES).
- ADDR_W, 32: address width.
- RD_LAT, 1: cycles from the SRAM grant cycle to valid `sram_rdata`; must be ≥1.

Ports:
- clk  in  1  clock. One clock domain; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword (legal only when DATA_W=64).
- req_signed  in  1  sign-extend load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- rsp_adel  out  1  load address error.
- rsp_ades  out  1  store address error.
- sram_en  out  1  SRAM access request; held until granted.
- sram_we  out  BYTES  byte write enables; all 0 for loads.
- sram_addr  out  ADDR_W  `req_addr` with the low LANE_W bits cleared.
- sram_wdata  out  DATA_W  lane-shifted store data.
- sram_gnt  in  1  SRAM accepts the current access.
- sram_rdata  in  DATA_W  SRAM read data.
- bad_vaddr  out  ADDR_W  faulting address; present only with MEMSEL_BADVADDR_EN.

## Operation
- FSM states: IDLE, ACC, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&`req_ready`, latch all `req_*` fields.
  - Misaligned request → RESP; otherwise → ACC.
- Misalignment: any of `addr[size-1:0]`≠0 for size≥1. Also any size with (1<<size) > BYTES, e.g. size 3 at DATA_W=32.
  - Load → `rsp_adel`=1; store → `rsp_ades`=1.
  - No SRAM access is issued.
- ACC:
  - Drive `sram_en`=1 with `sram_addr`, `sram_we`, `sram_wdata`; hold them stable until `sram_gnt`.
  - Store granted → RESP.
  - Load granted → WAIT with counter = RD_LAT-1.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter is 0, capture `sram_rdata` → RESP.
  - With RD_LAT=1, capture happens in the first WAIT cycle.
- RESP: `rsp_valid`=1 for exactly one cycle → IDLE. There is no backpressure; the consumer must take the response.
- Lane arithmetic: lane = `addr[LANE_W-1:0]`; nbytes = 1<<size.
  - `sram_we` = ((1<<nbytes)-1) << lane.
  - `sram_wdata` = `req_wdata` << (8·lane); upper bits beyond DATA_W are truncated.
- Load result: (`rdata` >> 8·lane), masked to 8·nbytes bits, then extended to DATA_W.
  - Sign-extend if `req_signed`, else zero-extend.
  - Full-width loads ignore `req_signed`.
- Only one transaction is in flight at a time. `req_valid` outside IDLE is ignored, not queued.

## Timing
- Reset values: state IDLE; `req_ready`=0 while `rst` asserted; `rsp_valid`, `rsp_rdata`, `rsp_adel`, `rsp_ades`, `sram_en`, `sram_we`, `sram_addr`, `sram_wdata`, `bad_vaddr` all 0.
- Accept in cycle T:
  - Error → `rsp_valid` at T+1.
  - Store with immediate grant → `sram_en` at T+1, `rsp_valid` at T+2.
  - Load with immediate grant → capture at T+1+RD_LAT, `rsp_valid` at T+2+RD_LAT.
- Each cycle of `sram_gnt`=0 in ACC adds one cycle to the response.
- `req_ready` rises in the cycle after RESP, giving a minimum issue interval of 2 cycles (error case).
- Reset mid-transaction: the next cycle is IDLE-reset state and `sram_en` drops. No response is produced, and the in-flight data is discarded.
- `sram_gnt` outside ACC is ignored.

## Configuration
- MEMSEL_BADVADDR_EN defined:
  - `bad_vaddr` port exists and holds the full `req_addr` of the most recent errored request.
  - It is updated in the cycle `rsp_valid` is asserted with an error flag, and held otherwise.
  - Reset value is 0.
- Not defined: the port and its register are absent. All other behaviour is identical.

## Test plan
- DATA_W=32, RD_LAT=1: LB signed at addr 0x1003, sram_rdata 0x80FF_1234, immediate grant → `rsp_rdata` 0xFFFF_FF80, `rsp_valid` at T+3.
- SH at 0x2002, wdata 0x0000_BEEF → `sram_we` 4'b1100, `sram_wdata` 0xBEEF_0000, `sram_addr` 0x2000, `rsp_valid` at T+2.
- LW at 0x3001 → `rsp_adel`=1 at T+1, `sram_en` never asserted, `bad_vaddr`=0x3001 (macro on); SD at DATA_W=32 → `rsp_ades`=1.
- RD_LAT=3, `sram_gnt` low for 2 cycles, LHU at 0x4006, rdata 0x8001_0000 → `sram_en` held T+1..T+3, `rsp_rdata` 0x0000_8001, `rsp_valid` at T+7.
- DATA_W=64: SB at 0x5005, wdata 0xAA → `sram_we` 8'b0010_0000; LD at 0x5008 returns `sram_rdata` unchanged.
- `rst` asserted in WAIT → `sram_en`=0 and no `rsp_valid`; `req_ready`=1 in the first cycle after `rst` deasserts.
